// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared output-mode constants and fill-counter sizing for the serial pattern detectors
package seq_det_pkg;
  localparam int MODE_MEALY = 0;
  localparam int MODE_MOORE = 1;
  function automatic int fill_w(input int len);
    return $clog2(len + 1);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit counter (clk, rst sync high, inc) -> q, increments on inc and sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) q <= rst ? '0 : (inc && !(&q)) ? q + W'(1) : q;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector (clk, rst, en, j) -> det (Moore/Mealy), saturating match_count
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                     PATTERN_LEN = 5,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 5'b10010,
  parameter int                     MOORE       = MODE_MOORE,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             j,
  output logic             det,
  output logic [CNT_W-1:0] match_count
);
  localparam int FW = fill_w(PATTERN_LEN);
  if (PATTERN_LEN < 2 || PATTERN_LEN > 16) begin : g_len_chk
    $error("seq_detector_param: PATTERN_LEN must be 2..16");
  end
  logic [PATTERN_LEN-1:0] hist, shifted;
  logic [FW-1:0]          fill;
  logic                   hit, match;
  always_comb begin
    shifted = {hist[PATTERN_LEN-2:0], j};
    match   = en && !rst && (fill >= FW'(PATTERN_LEN - 1)) && (shifted == PATTERN);
    det     = (MOORE == MODE_MOORE) ? hit : match;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
      hit  <= 1'b0;
    end else if (en) begin
      hist <= shifted;
      hit  <= match;
      fill <= (match && !OVERLAP) ? '0 : (fill == FW'(PATTERN_LEN)) ? fill : fill + FW'(1);
    end
  end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(match),
    .q  (match_count)
  );
endmodule
